// File: rtl/echo_delay_if.sv
// echo_delay_if: cs/my_turn/done sample handshake between the chain scheduler and a stage.
interface echo_delay_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         cs;
    logic                         my_turn;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         done;
    logic signed [DATA_WIDTH-1:0] data_out;

    modport master (output cs, my_turn, data_in, input done, data_out);
    modport slave  (input cs, my_turn, data_in, output done, data_out);
endinterface

// File: rtl/echo_delay.sv
// echo_delay: feedback echo stage mixing each sample with a delayed copy from a circular buffer.
module echo_delay #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         control_key1,
    echo_delay_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] D_MID = ADDR_WIDTH'(DEPTH / 4);
    localparam logic [ADDR_WIDTH-1:0] D_MAX = '1;

    typedef enum logic [1:0] {IDLE, READ, MIX, DONE} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        wp_q, wp_d, rp_q, rp_d, dly_q, dly_d, dsel;
    logic [ADDR_WIDTH:0]          fill_q, fill_d;
    logic [1:0]                   opt_q, opt_d;
    logic                         key_q, we;
    logic signed [DATA_WIDTH-1:0] x_q, x_d, dout_q, dout_d, rdata_q, y, y_half, y_quart, w;
    logic signed [DATA_WIDTH:0]   sum_out, sum_fb;
    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] s);
        return (s[DATA_WIDTH] != s[DATA_WIDTH-1]) ?
            {s[DATA_WIDTH], {(DATA_WIDTH-1){~s[DATA_WIDTH]}}} : s[DATA_WIDTH-1:0];
    endfunction

    assign dsel    = (opt_q == 2'd1) ? D_MID : (opt_q == 2'd2) ? D_MAX : '0;
    // A zero latched delay means bypass; stale RAM is hidden until the buffer has filled to D
    assign y       = (dly_q == '0 || fill_q < {1'b0, dly_q}) ? '0 : rdata_q;
    assign y_half  = y >>> 1;
    assign y_quart = y >>> 2;
    assign sum_out = {x_q[DATA_WIDTH-1], x_q} + {y_half[DATA_WIDTH-1], y_half};
    assign sum_fb  = {x_q[DATA_WIDTH-1], x_q} + {y_quart[DATA_WIDTH-1], y_quart};
    assign w       = sat(sum_fb);
    assign opt_d   = (control_key1 && !key_q) ? ((opt_q == 2'd2) ? 2'd0 : opt_q + 2'd1) : opt_q;

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        fill_d  = fill_q;
        x_d     = x_q;
        dly_d   = dly_q;
        dout_d  = dout_q;
        we      = 1'b0;
        case (state_q)
            IDLE: if (bus.cs && bus.my_turn) begin
                x_d     = bus.data_in;
                dly_d   = dsel;
                rp_d    = wp_q - dsel;
                state_d = READ;
            end
            READ: state_d = MIX;
            MIX: begin
                we      = 1'b1;
                wp_d    = wp_q + ADDR_WIDTH'(1);
                fill_d  = fill_q[ADDR_WIDTH] ? fill_q : fill_q + (ADDR_WIDTH+1)'(1);
                dout_d  = (dly_q == '0) ? x_q : sat(sum_out);
                state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            fill_q  <= '0;
            x_q     <= '0;
            dly_q   <= '0;
            dout_q  <= '0;
            opt_q   <= '0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            fill_q  <= fill_d;
            x_q     <= x_d;
            dly_q   <= dly_d;
            dout_q  <= dout_d;
            opt_q   <= opt_d;
            key_q   <= control_key1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wp_q] <= w;
        if (state_q == READ) rdata_q <= mem[rp_q];
    end

    assign bus.done     = (state_q == DONE);
    assign bus.data_out = dout_q;
endmodule

// File: tb/tb_echo_delay.sv
// tb_echo_delay: vector table, directed echo/saturation/wrap/reset sequences and random traffic vs a sample-history model.
module tb_echo_delay;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic control_key1 = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   mopt = 0;
    int   wh[$];

    echo_delay_if #(.DATA_WIDTH(16)) bus ();

    echo_delay dut (.clk(clk), .rst(rst), .control_key1(control_key1), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int presses;
        int x;
        int exp;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int msat(input int s);
        return (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
    endfunction

    function automatic int mdelay(input int opt);
        return (opt == 1) ? 256 : (opt == 2) ? 1023 : 0;
    endfunction

    // Echo source is simply the feedback value written D samples ago, if that many exist since reset
    task automatic model(input int x, input int d, output int out);
        int n, y;
        n   = wh.size();
        y   = (d == 0 || n < d) ? 0 : wh[n-d];
        out = (d == 0) ? x : msat(x + (y >>> 1));
        wh.push_back(msat(x + (y >>> 2)));
    endtask

    task automatic press();
        @(negedge clk);
        control_key1 = 1'b1;
        @(negedge clk);
        control_key1 = 1'b0;
        @(negedge clk);
        mopt = (mopt + 1) % 3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wh.delete();
        mopt = 0;
    endtask

    task automatic req(input int x, input bit kp, output int got);
        int d, exp, cyc;
        d = mdelay(mopt);
        @(negedge clk);
        bus.cs = 1'b1;
        bus.my_turn = 1'b1;
        bus.data_in = 16'(x);
        @(posedge clk);
        #1;
        bus.my_turn = 1'b0;
        bus.cs = $urandom_range(0, 1) == 1;
        bus.data_in = 16'($urandom);
        if (kp) begin
            control_key1 = 1'b1;
            mopt = (mopt + 1) % 3;
        end
        cyc = 0;
        while (cyc < 6 && bus.done !== 1'b1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) control_key1 = 1'b0;
        end
        check("latency", cyc, 2);
        got = $signed(bus.data_out);
        model(x, d, exp);
        check("data_out", got, exp);
        @(posedge clk);
        #1;
        bus.cs = 1'b0;
        check("done_width", int'(bus.done), 0);
        check("hold", $signed(bus.data_out), exp);
    endtask

    initial begin
        vec_t vt[7];
        int got;
        bus.cs = 1'b0;
        bus.my_turn = 1'b0;
        bus.data_in = '0;
        vt[0] = '{0, 1000, 1000};
        vt[1] = '{0, -1, -1};
        vt[2] = '{0, 32767, 32767};
        vt[3] = '{0, -32768, -32768};
        vt[4] = '{1, 5000, 5000};
        vt[5] = '{1, -7, -7};
        vt[6] = '{1, 123, 123};

        // Requests presented during reset must be ignored
        repeat (2) @(negedge clk);
        bus.cs = 1'b1;
        bus.my_turn = 1'b1;
        bus.data_in = 16'sd999;
        repeat (3) @(negedge clk);
        check("reset_done", int'(bus.done), 0);
        check("reset_dout", $signed(bus.data_out), 0);
        bus.cs = 1'b0;
        bus.my_turn = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            repeat (vt[i].presses) press();
            req(vt[i].x, 1'b0, got);
            check($sformatf("vec%0d", i), got, vt[i].exp);
        end

        // my_turn without cs is not a request
        @(negedge clk);
        bus.my_turn = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("no_cs", int'(bus.done), 0);
        end
        bus.my_turn = 1'b0;

        // Impulse at option 1
        do_reset();
        press();
        for (int i = 0; i <= 520; i++) begin
            req((i == 0) ? 8000 : 0, 1'b0, got);
            if (i == 0 || i == 1 || i == 256 || i == 300 || i == 512)
                check($sformatf("impulse%0d", i), got,
                      (i == 0) ? 8000 : (i == 256) ? 4000 : (i == 512) ? 1000 : 0);
        end

        // Saturation both directions
        for (int s = 0; s < 2; s++) begin
            do_reset();
            press();
            for (int i = 0; i <= 256; i++) req(s ? -30000 : 30000, 1'b0, got);
            check(s ? "sat_neg" : "sat_pos", got, s ? -32768 : 32767);
        end

        // Wrap-around at option 2
        do_reset();
        press();
        press();
        for (int i = 0; i < 1100; i++) begin
            req(i, 1'b0, got);
            if (i == 1050) check("wrap1050", got, 1063);
            if (i == 1099) check("wrap1099", got, 1137);
        end

        // Key press while a sample is in flight: 2->0 applies only to the next sample
        req(-20000, 1'b1, got);
        req(4321, 1'b0, got);
        check("bypass_after", got, 4321);
        req(-555, 1'b1, got);
        check("old_bypass", got, -555);
        req(777, 1'b0, got);
        press();
        req(888, 1'b0, got);
        press();
        req(-999, 1'b0, got);
        check("three_press", got, -999);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) press();
            req($signed(16'($urandom)), $urandom_range(0, 9) == 0, got);
        end

        // Asynchronous reset while the sample is in MIX
        @(negedge clk);
        bus.cs = 1'b1;
        bus.my_turn = 1'b1;
        bus.data_in = 16'sd1234;
        @(posedge clk);
        #1;
        bus.cs = 1'b0;
        bus.my_turn = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mix_rst_done", int'(bus.done), 0);
        check("mix_rst_dout", $signed(bus.data_out), 0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("mix_rst_nodone", int'(bus.done), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        wh.delete();
        mopt = 0;
        press();
        for (int i = 0; i < 258; i++) begin
            int x;
            x = $signed(16'($urandom));
            req(x, 1'b0, got);
            if (i < 256 && (i % 64 == 0 || i == 255)) check($sformatf("post_rst%0d", i), got, x);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
